alarm_key_controller: RTL and testbench
=======================================

// Module: alarm_key_controller
// PURPOSE
//  Sequencing controller for the single-digit alarm-clock display path. Owns the key buffer, the
//  alarm register and the current-time digit counter, and drives the lcd_driver selects
//  (show_a, show_new_time) and data (key, alarm_time, current_time). Sits between the keypad
//  scanner/button debouncers and the lcd_driver; the buzzer decode stays in the lcd_driver.
// PARAMETERS
//  TIMEOUT_TICKS   10  one_second ticks of key inactivity before key entry is abandoned
//  TICKS_PER_STEP  60  one_second ticks per current_time increment (>=1)
// PORTS
//  clock          in   1  system clock, all state on rising edge
//  reset_n        in   1  reset is asynchronous and active-low
//  one_second     in   1  1-cycle pulse, one per second, synchronous to clock
//  key_valid      in   1  1-cycle pulse: key holds a new keypress
//  key            in   4  keypad code; 0-9 digits, 10-15 non-digit (ignored)
//  alarm_button   in   1  debounced level: store alarm / show alarm
//  time_button    in   1  debounced level: store current time
//  key_buf        out  4  buffered entered digit, to lcd_driver key
//  alarm_time     out  4  alarm digit register, 0-9
//  current_time   out  4  current-time digit counter, 0-9
//  show_a         out  1  select alarm_time on display
//  show_new_time  out  1  select key_buf on display
// BEHAVIOUR
//  Reset: state=SHOW_TIME; key_buf, alarm_time, current_time, step_cnt, timeout_cnt = 0;
//   show_a=show_new_time=0. (lcd_driver sound=1 out of reset since digits match; accepted.)
//  All outputs registered; decode of next state, so selects change with the state, 1-cycle latency.
//  digit = key_valid && key<=9. Non-digit keys never change state or registers.
//  SHOW_TIME (show_a=0, show_new_time=0):
//   - digit -> KEY_ENTRY, key_buf<=key, timeout_cnt<=0 (digit wins over alarm_button same cycle)
//   - else alarm_button=1 -> SHOW_ALARM
//   - time_button alone: no effect
//  KEY_ENTRY (show_new_time=1):
//   - alarm_button=1 -> alarm_time<=key_buf, -> SHOW_TIME (alarm_button wins over time_button)
//   - else time_button=1 -> current_time<=key_buf, step_cnt<=0, -> SHOW_TIME
//   - buttons win over a same-cycle digit; the stored value is the old key_buf
//   - else digit -> key_buf<=key, timeout_cnt<=0, stay
//   - else one_second: timeout_cnt+1; when it reaches TIMEOUT_TICKS -> SHOW_TIME, nothing stored
//  SHOW_ALARM (show_a=1): stay while alarm_button=1; release -> SHOW_TIME. Keys ignored.
//   After an alarm store, a still-held alarm_button does not re-enter SHOW_ALARM until released
//   (one cycle in SHOW_TIME with alarm_button=0 required; track via a release flag).
//  Timekeeping, all states: on one_second step_cnt+1; at TICKS_PER_STEP-1 step_cnt<=0 and
//   current_time+1 with wrap 9->0. A same-cycle time_button load overrides the increment.
//  timeout_cnt/step_cnt width $clog2(max(param,2))+1; saturate, never wrap.
//  Async reset mid-entry: abandons entry, all registers to reset values, nothing stored.
// TESTING
//  1 reset, 60 one_second ticks (TICKS_PER_STEP=60) -> current_time 0->1; 600 ticks -> wraps 9->0
//  2 key=7 pulse, alarm_button=1 -> show_new_time=1 then 0, alarm_time=7, show_a stays 0 while held
//  3 key=3, key=5, time_button=1 -> current_time=5, step_cnt cleared, state SHOW_TIME
//  4 key=4 then 10 idle one_second ticks -> back to SHOW_TIME, alarm_time/current_time unchanged
//  5 key=12 in SHOW_TIME -> no state change; alarm_button held in SHOW_TIME -> show_a=1, release->0
//  6 KEY_ENTRY with key_buf=2, same cycle key=8 + alarm_button -> alarm_time=2; reset_n low mid-entry -> all 0

Source files
------------

// File: rtl/alarm_key_controller_if.sv
// Signal bundle between the keypad/button front end, the alarm key controller and the lcd_driver.
// The master drives the keypad/button/tick inputs; the slave (controller) drives the display path.
interface alarm_key_controller_if;
  // Pulse semantics, no back-pressure: one_second and key_valid are single-cycle strobes that the
  // controller always accepts in the cycle they are high; key is only meaningful while key_valid=1.
  // Buttons are debounced levels. All slave outputs are registered.
  logic       one_second;
  logic       key_valid;
  logic [3:0] key;
  logic       alarm_button;
  logic       time_button;

  logic [3:0] key_buf;
  logic [3:0] alarm_time;
  logic [3:0] current_time;
  logic       show_a;
  logic       show_new_time;
  // Debug view of the controller FSM: 0=SHOW_TIME, 1=KEY_ENTRY, 2=SHOW_ALARM
  logic [1:0] state_dbg;

  modport master (
    output one_second, key_valid, key, alarm_button, time_button,
    input  key_buf, alarm_time, current_time, show_a, show_new_time, state_dbg
  );

  modport slave (
    input  one_second, key_valid, key, alarm_button, time_button,
    output key_buf, alarm_time, current_time, show_a, show_new_time, state_dbg
  );
endinterface

// File: rtl/alarm_key_controller.sv
// Sequencing controller for the single-digit alarm clock: owns the key buffer, alarm register and
// current-time digit counter, and drives the lcd_driver selects from a registered next-state decode.
module alarm_key_controller #(
  parameter int TIMEOUT_TICKS  = 10,
  parameter int TICKS_PER_STEP = 60
) (
  input  logic                   clock,
  input  logic                   reset_n,
  alarm_key_controller_if.slave  bus
);

  localparam int TW = $clog2((TIMEOUT_TICKS  > 2) ? TIMEOUT_TICKS  : 2) + 1;
  localparam int SW = $clog2((TICKS_PER_STEP > 2) ? TICKS_PER_STEP : 2) + 1;
  localparam logic [TW-1:0] TO_LAST   = TW'((TIMEOUT_TICKS  > 1) ? TIMEOUT_TICKS  - 1 : 0);
  localparam logic [SW-1:0] STEP_LAST = SW'((TICKS_PER_STEP > 1) ? TICKS_PER_STEP - 1 : 0);
  localparam logic [TW-1:0] TO_MAX    = '1;
  localparam logic [SW-1:0] STEP_MAX  = '1;

  typedef enum logic [1:0] {
    SHOW_TIME  = 2'd0,
    KEY_ENTRY  = 2'd1,
    SHOW_ALARM = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    key_buf_q, key_buf_d;
  logic [3:0]    alarm_time_q, alarm_time_d;
  logic [3:0]    current_time_q, current_time_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic [TW-1:0] timeout_cnt_q, timeout_cnt_d;
  logic          show_a_q, show_a_d;
  logic          show_new_time_q, show_new_time_d;
  // Set once alarm_button has been seen low; cleared by an alarm store so a held button
  // does not fall straight through into SHOW_ALARM.
  logic          alarm_armed_q, alarm_armed_d;

  logic digit;
  assign digit = bus.key_valid && (bus.key <= 4'd9);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= SHOW_TIME;
      key_buf_q       <= 4'd0;
      alarm_time_q    <= 4'd0;
      current_time_q  <= 4'd0;
      step_cnt_q      <= '0;
      timeout_cnt_q   <= '0;
      show_a_q        <= 1'b0;
      show_new_time_q <= 1'b0;
      alarm_armed_q   <= 1'b1;
    end else begin
      state_q         <= state_d;
      key_buf_q       <= key_buf_d;
      alarm_time_q    <= alarm_time_d;
      current_time_q  <= current_time_d;
      step_cnt_q      <= step_cnt_d;
      timeout_cnt_q   <= timeout_cnt_d;
      show_a_q        <= show_a_d;
      show_new_time_q <= show_new_time_d;
      alarm_armed_q   <= alarm_armed_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    key_buf_d      = key_buf_q;
    alarm_time_d   = alarm_time_q;
    current_time_d = current_time_q;
    step_cnt_d     = step_cnt_q;
    timeout_cnt_d  = timeout_cnt_q;
    alarm_armed_d  = alarm_armed_q;

    if (!bus.alarm_button) begin
      alarm_armed_d = 1'b1;
    end

    // Timekeeping runs in every state; a time_button load below overrides it.
    if (bus.one_second) begin
      if (step_cnt_q >= STEP_LAST) begin
        step_cnt_d     = '0;
        current_time_d = (current_time_q >= 4'd9) ? 4'd0 : current_time_q + 4'd1;
      end else if (step_cnt_q != STEP_MAX) begin
        step_cnt_d = step_cnt_q + SW'(1);
      end
    end

    unique case (state_q)
      SHOW_TIME: begin
        if (digit) begin
          state_d       = KEY_ENTRY;
          key_buf_d     = bus.key;
          timeout_cnt_d = '0;
        end else if (bus.alarm_button && alarm_armed_q) begin
          state_d = SHOW_ALARM;
        end
      end

      KEY_ENTRY: begin
        // Buttons take priority over a same-cycle digit and store the already-buffered value.
        if (bus.alarm_button) begin
          alarm_time_d  = key_buf_q;
          alarm_armed_d = 1'b0;
          state_d       = SHOW_TIME;
        end else if (bus.time_button) begin
          current_time_d = key_buf_q;
          step_cnt_d     = '0;
          state_d        = SHOW_TIME;
        end else if (digit) begin
          key_buf_d     = bus.key;
          timeout_cnt_d = '0;
        end else if (bus.one_second) begin
          if (timeout_cnt_q != TO_MAX) begin
            timeout_cnt_d = timeout_cnt_q + TW'(1);
          end
          if (timeout_cnt_q >= TO_LAST) begin
            state_d = SHOW_TIME;
          end
        end
      end

      SHOW_ALARM: begin
        if (!bus.alarm_button) begin
          state_d = SHOW_TIME;
        end
      end

      default: begin
        state_d = SHOW_TIME;
      end
    endcase

    show_a_d        = (state_d == SHOW_ALARM);
    show_new_time_d = (state_d == KEY_ENTRY);
  end

  assign bus.key_buf       = key_buf_q;
  assign bus.alarm_time    = alarm_time_q;
  assign bus.current_time  = current_time_q;
  assign bus.show_a        = show_a_q;
  assign bus.show_new_time = show_new_time_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_alarm_key_controller.sv
// Bench for alarm_key_controller: directed sequences with expected display-path snapshots
// queued as stimulus is applied and compared after each clocked step.
module tb_alarm_key_controller;

  localparam logic [1:0] ST = 2'd0;
  localparam logic [1:0] KE = 2'd1;
  localparam logic [1:0] SA = 2'd2;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  alarm_key_controller_if bus ();

  alarm_key_controller #(
    .TIMEOUT_TICKS  (10),
    .TICKS_PER_STEP (60)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic expect_out(input logic [1:0] st, input logic sa, input logic snt,
                            input logic [3:0] kb, input logic [3:0] al, input logic [3:0] ct);
    exp_q.push_back({st, sa, snt, kb, al, ct});
  endtask

  task automatic check_out(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no expectation expected one queued", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".state"},         {2'b00, bus.state_dbg},     {2'b00, e[15:14]});
    chk({tag, ".show_a"},        {3'b000, bus.show_a},       {3'b000, e[13]});
    chk({tag, ".show_new_time"}, {3'b000, bus.show_new_time}, {3'b000, e[12]});
    chk({tag, ".key_buf"},       bus.key_buf,                e[11:8]);
    chk({tag, ".alarm_time"},    bus.alarm_time,             e[7:4]);
    chk({tag, ".current_time"},  bus.current_time,           e[3:0]);
  endtask

  task automatic expect_now(input string tag, input logic [1:0] st, input logic sa,
                            input logic snt, input logic [3:0] kb, input logic [3:0] al,
                            input logic [3:0] ct);
    expect_out(st, sa, snt, kb, al, ct);
    check_out(tag);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key       = k;
    cyc();
    bus.key_valid = 1'b0;
    bus.key       = 4'd0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      bus.one_second = 1'b1;
      cyc();
      bus.one_second = 1'b0;
      cyc();
    end
  endtask

  task automatic do_reset();
    bus.one_second   = 1'b0;
    bus.key_valid    = 1'b0;
    bus.key          = 4'd0;
    bus.alarm_button = 1'b0;
    bus.time_button  = 1'b0;
    reset_n = 1'b0;
    cyc();
    cyc();
    expect_now("reset", ST, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    // 1: timekeeping step and digit wrap
    do_reset();
    tick(59);
    expect_now("t1_59", ST, 0, 0, 0, 0, 0);
    tick(1);
    expect_now("t1_60", ST, 0, 0, 0, 0, 1);
    tick(480);
    expect_now("t1_540", ST, 0, 0, 0, 0, 9);
    tick(60);
    expect_now("t1_wrap", ST, 0, 0, 0, 0, 0);

    // 2: alarm store, held button does not re-enter SHOW_ALARM until released
    do_reset();
    press(4'd7);
    expect_now("t2_key", KE, 0, 1, 7, 0, 0);
    bus.alarm_button = 1'b1;
    cyc();
    expect_now("t2_store", ST, 0, 0, 7, 7, 0);
    cyc(); cyc(); cyc();
    expect_now("t2_held", ST, 0, 0, 7, 7, 0);
    bus.alarm_button = 1'b0;
    cyc();
    expect_now("t2_rel", ST, 0, 0, 7, 7, 0);
    bus.alarm_button = 1'b1;
    cyc();
    expect_now("t2_show", SA, 1, 0, 7, 7, 0);
    bus.alarm_button = 1'b0;
    cyc();
    expect_now("t2_back", ST, 0, 0, 7, 7, 0);

    // 3: time store clears the step counter; time_button alone in SHOW_TIME is inert
    do_reset();
    bus.time_button = 1'b1;
    cyc();
    bus.time_button = 1'b0;
    expect_now("t3_tbtn", ST, 0, 0, 0, 0, 0);
    tick(30);
    press(4'd3);
    expect_now("t3_k3", KE, 0, 1, 3, 0, 0);
    press(4'd5);
    expect_now("t3_k5", KE, 0, 1, 5, 0, 0);
    bus.time_button = 1'b1;
    cyc();
    bus.time_button = 1'b0;
    expect_now("t3_store", ST, 0, 0, 5, 0, 5);
    tick(59);
    expect_now("t3_59", ST, 0, 0, 5, 0, 5);
    tick(1);
    expect_now("t3_60", ST, 0, 0, 5, 0, 6);

    // 4: inactivity timeout, restarted by a fresh digit
    do_reset();
    press(4'd6);
    bus.alarm_button = 1'b1;
    cyc();
    bus.alarm_button = 1'b0;
    cyc();
    expect_now("t4_alarm", ST, 0, 0, 6, 6, 0);
    press(4'd4);
    expect_now("t4_key", KE, 0, 1, 4, 6, 0);
    tick(5);
    press(4'd4);
    tick(9);
    expect_now("t4_9", KE, 0, 1, 4, 6, 0);
    tick(1);
    expect_now("t4_10", ST, 0, 0, 4, 6, 0);

    // 5: non-digit ignored, SHOW_ALARM ignores keys, digit beats alarm_button in SHOW_TIME
    do_reset();
    press(4'd12);
    expect_now("t5_nd", ST, 0, 0, 0, 0, 0);
    bus.alarm_button = 1'b1;
    cyc();
    expect_now("t5_sa", SA, 1, 0, 0, 0, 0);
    press(4'd5);
    expect_now("t5_sakey", SA, 1, 0, 0, 0, 0);
    bus.alarm_button = 1'b0;
    cyc();
    expect_now("t5_rel", ST, 0, 0, 0, 0, 0);
    bus.alarm_button = 1'b1;
    press(4'd9);
    bus.alarm_button = 1'b0;
    expect_now("t5_prio", KE, 0, 1, 9, 0, 0);

    // 6: button beats same-cycle digit; async reset mid-entry
    do_reset();
    press(4'd2);
    expect_now("t6_k2", KE, 0, 1, 2, 0, 0);
    bus.alarm_button = 1'b1;
    press(4'd8);
    bus.alarm_button = 1'b0;
    expect_now("t6_store", ST, 0, 0, 2, 2, 0);
    cyc();
    press(4'd3);
    expect_now("t6_k3", KE, 0, 1, 3, 2, 0);
    #2;
    reset_n = 1'b0;
    #1;
    expect_now("t6_arst", ST, 0, 0, 0, 0, 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    expect_now("t6_after", ST, 0, 0, 0, 0, 0);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d queued expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
